ysyx_23060332_mem_arbiter: RTL and testbench
============================================

# ysyx_23060332_mem_arbiter

Shares the core's single memory port between the instruction fetch unit (IFU) and the load/store path of the execute unit (LSU). It accepts one request at a time from either requester through a valid/ready handshake, drives the memory port, and routes the single response back to the owner. It sits between IFU/EXU and the memory/SRAM model, so the EXU's load/store outputs become a handshaked request stream.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- ifu_req_valid  input  1  IFU fetch request (read only)
- ifu_req_ready  output  1  IFU request accepted this cycle when both are high
- ifu_addr  input  ADDR_W  fetch address
- ifu_rsp_valid  output  1  fetch data valid, one-cycle pulse
- ifu_rdata  output  DATA_W  fetch data
- lsu_req_valid  input  1  LSU load/store request
- lsu_req_ready  output  1  LSU request accepted
- lsu_wen  input  1  1 = store, 0 = load
- lsu_addr  input  ADDR_W  load/store address
- lsu_wdata  input  DATA_W  store data
- lsu_wmask  input  8  byte mask (0x01 SB, 0x03 SH, 0x0F SW)
- lsu_rsp_valid  output  1  load data valid / store complete, one-cycle pulse
- lsu_rdata  output  DATA_W  load data (0 on store completion)
- m_req_valid  output  1  memory request valid
- m_req_ready  input  1  memory accepts request
- m_wen, m_addr, m_wdata, m_wmask  output  1/ADDR_W/DATA_W/8  latched request fields
- m_rsp_valid  input  1  memory response valid
- m_rdata  input  DATA_W  memory read data
- busy  output  1  state != IDLE

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: req_ready high only for the requester selected by arbitration (combinational on current valids); on valid&&ready, latch owner, wen, addr, wdata, wmask (IFU: wen=0, wdata=0, wmask=0) -> REQ. No valids -> stay IDLE, both ready low.
- Arbitration default: LSU wins ties (fixed priority).
- REQ: m_req_valid=1 with latched fields, held stable until m_req_ready; then -> WAIT. Both req_ready low.
- WAIT: on m_rsp_valid, pulse owner's rsp_valid, pass m_rdata to owner's rdata (LSU store: rdata 0) -> IDLE. Other requester's rsp_valid stays 0.
- m_rsp_valid in IDLE or REQ: ignored, no rsp pulse.
- Exactly one outstanding memory transaction ever.
- Reset: state IDLE, owner/latched fields 0; outputs: all req_ready 0 while rst_n low, rsp_valid 0, rdata 0, m_req_valid 0, m_* fields 0, busy 0.
- Reset mid-transaction: abandons it; a late m_rsp_valid after reset arrives in IDLE and is dropped.

## Timing
- Request handshake cycle N (IDLE); m_req_valid first high N+1.
- m_req_ready at N+1 -> WAIT at N+2; earliest rsp_valid at N+2 (combinational from m_rsp_valid in WAIT).
- Minimum round trip: 3 cycles accept-to-next-accept (next req_ready at N+3).
- m_* fields registered; rsp path combinational, gated by state==WAIT and owner.
- Requester must hold valid and fields until ready; arbiter never drops a held request.

## Configuration
- YSYX_23060332_ARB_RR_EN defined: round-robin on ties. Register last_owner (reset = IFU) updated at each accept; tie grants the requester that is not last_owner, so first tie after reset goes to LSU, next to IFU, alternating.
- Undefined: fixed priority, LSU always wins ties; no last_owner register. Non-tie behaviour identical.

## Test plan
- IFU-only read 0x8000_0000, memory ready immediately, m_rdata=0x0010_0093 -> m_req_valid at N+1 with m_wen=0, ifu_rsp_valid pulse N+2 with ifu_rdata=0x0010_0093, lsu_rsp_valid 0.
- LSU SB addr 0x8000_0104 wdata 0xAB wmask 0x01, m_req_ready delayed 3 cycles -> m_addr/m_wdata/m_wmask stable all 3 cycles, lsu_rsp_valid one cycle after response, lsu_rdata=0.
- Both valid every cycle for 4 transactions -> RR_EN: grant order LSU, IFU, LSU, IFU; without: LSU ×4 while IFU stalls.
- Spurious m_rsp_valid in IDLE and in REQ -> no rsp_valid pulse, state unchanged.
- rst_n low for one cycle while in WAIT, then m_rsp_valid=1 -> busy 0 after reset, no rsp_valid pulse, all outputs at reset values.

Source files
------------

// File: rtl/ysyx_23060332_mem_arbiter.sv
// ysyx_23060332_mem_arbiter: shares one memory port between IFU fetches and LSU loads/stores.
// Define YSYX_23060332_ARB_RR_EN for round-robin tie-breaking; otherwise the LSU always wins ties.
module ysyx_23060332_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [7:0]        m_wmask,
    input  logic              m_rsp_valid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   owner_r;      // 1'b1 = LSU owns the transaction, 1'b0 = IFU
    logic   grant_lsu_s;
    logic   accept_s;
    logic   rsp_fire_s;

`ifdef YSYX_23060332_ARB_RR_EN
    logic   last_lsu_r;

    // Remember who was granted last so the next tie goes to the other requester.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_lsu_r <= 1'b0;
        end else if (accept_s) begin
            last_lsu_r <= grant_lsu_s;
        end else begin
            last_lsu_r <= last_lsu_r;
        end
    end
`endif

    // Arbitration on the current valids; only the tie case depends on the build option.
    always_comb begin
        grant_lsu_s = 1'b0;
        if (lsu_req_valid && ifu_req_valid) begin
`ifdef YSYX_23060332_ARB_RR_EN
            grant_lsu_s = ~last_lsu_r;
`else
            grant_lsu_s = 1'b1;
`endif
        end else begin
            grant_lsu_s = lsu_req_valid;
        end
    end

    // Next-state and request-side handshake decode.
    always_comb begin
        state_s       = state_r;
        lsu_req_ready = 1'b0;
        ifu_req_ready = 1'b0;
        accept_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (rst_n && (lsu_req_valid || ifu_req_valid)) begin
                    lsu_req_ready = grant_lsu_s;
                    ifu_req_ready = ~grant_lsu_s;
                    accept_s      = 1'b1;
                    state_s       = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (m_req_ready) begin
                    state_s = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (m_rsp_valid) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch the winning request; fields stay frozen until the next accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_r <= 1'b0;
            m_wen   <= 1'b0;
            m_addr  <= {ADDR_W{1'b0}};
            m_wdata <= {DATA_W{1'b0}};
            m_wmask <= 8'h00;
        end else if (accept_s && grant_lsu_s) begin
            owner_r <= 1'b1;
            m_wen   <= lsu_wen;
            m_addr  <= lsu_addr;
            m_wdata <= lsu_wdata;
            m_wmask <= lsu_wmask;
        end else if (accept_s) begin
            owner_r <= 1'b0;
            m_wen   <= 1'b0;
            m_addr  <= ifu_addr;
            m_wdata <= {DATA_W{1'b0}};
            m_wmask <= 8'h00;
        end else begin
            owner_r <= owner_r;
            m_wen   <= m_wen;
            m_addr  <= m_addr;
            m_wdata <= m_wdata;
            m_wmask <= m_wmask;
        end
    end

    // Responses outside WAIT are stray and never reach a requester.
    assign rsp_fire_s    = rst_n && (state_r == WAIT) && m_rsp_valid;
    assign lsu_rsp_valid = rsp_fire_s && owner_r;
    assign ifu_rsp_valid = rsp_fire_s && !owner_r;
    assign lsu_rdata     = (lsu_rsp_valid && !m_wen) ? m_rdata : {DATA_W{1'b0}};
    assign ifu_rdata     = ifu_rsp_valid ? m_rdata : {DATA_W{1'b0}};
    assign m_req_valid   = rst_n && (state_r == REQ);
    assign busy          = (state_r != IDLE);

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// Self-checking bench for ysyx_23060332_mem_arbiter: arbitration table, directed corner cases,
// and a randomized run against a transaction-level reference model.
module tb_ysyx_23060332_mem_arbiter;

`ifdef YSYX_23060332_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        m_req_valid, m_req_ready, m_wen, m_rsp_valid, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [7:0]  m_wmask;

    int total = 0;
    int bad   = 0;

    ysyx_23060332_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_wen(m_wen), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rsp_valid(m_rsp_valid), .m_rdata(m_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic lv;
        logic iv;
        logic exp_lr;
        logic exp_ir;
    } arb_vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 1'b0; ifu_addr  = 32'h0;
        lsu_req_valid = 1'b0; lsu_wen   = 1'b0; lsu_addr = 32'h0;
        lsu_wdata     = 32'h0; lsu_wmask = 8'h00;
        m_req_ready   = 1'b0; m_rsp_valid = 1'b0; m_rdata = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {lsu_req_ready, ifu_req_ready}, 2'b00);
        check({tag, "_rsp"}, {lsu_rsp_valid, ifu_rsp_valid}, 2'b00);
        check({tag, "_rdata"}, {lsu_rdata, ifu_rdata}, 64'h0);
        check({tag, "_mreq"}, m_req_valid, 1'b0);
        check({tag, "_mfields"}, {m_wen, m_addr, m_wdata, m_wmask}, 73'h0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        arb_vec_t    vecs [4];
        logic        exp_l;
        bit          l_hold, i_hold, l_wen, busy_m, mem_acc, t_lsu, t_wen, last_lsu;
        bit          rsp_now, g_any, g_lsu;
        logic [31:0] l_addr, l_wdata, i_addr, t_addr, t_wdata;
        logic [7:0]  l_wmask, t_wmask;
        int          cnt;

        vecs[0] = '{lv: 1'b0, iv: 1'b0, exp_lr: 1'b0, exp_ir: 1'b0};
        vecs[1] = '{lv: 1'b1, iv: 1'b0, exp_lr: 1'b1, exp_ir: 1'b0};
        vecs[2] = '{lv: 1'b0, iv: 1'b1, exp_lr: 1'b0, exp_ir: 1'b1};
        vecs[3] = '{lv: 1'b1, iv: 1'b1, exp_lr: 1'b1, exp_ir: 1'b0};

        // Reset with requests pending: nothing may be granted.
        clear_inputs();
        rst_n = 1'b0;
        lsu_req_valid = 1'b1; ifu_req_valid = 1'b1;
        tick(); tick();
        settle();
        check("rst_low_ready", {lsu_req_ready, ifu_req_ready}, 2'b00);
        check("rst_low_rsp", {lsu_rsp_valid, ifu_rsp_valid}, 2'b00);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        settle();
        check_reset_outputs("post_rst");

        // Arbitration table in IDLE; valids drop before the edge so nothing is accepted.
        for (int i = 0; i < 4; i++) begin
            lsu_req_valid = vecs[i].lv;
            ifu_req_valid = vecs[i].iv;
            settle();
            check("arb_table", {lsu_req_ready, ifu_req_ready}, {vecs[i].exp_lr, vecs[i].exp_ir});
            lsu_req_valid = 1'b0;
            ifu_req_valid = 1'b0;
            tick();
        end

        // Both requesters valid for four back-to-back transactions.
        for (int k = 0; k < 4; k++) begin
            lsu_req_valid = 1'b1; ifu_req_valid = 1'b1;
            lsu_wen = 1'b0; lsu_addr = 32'h1000 + k; ifu_addr = 32'h2000 + k;
            settle();
            exp_l = RR ? (k % 2 == 0) : 1'b1;
            check("tie_grant", {lsu_req_ready, ifu_req_ready}, {exp_l, !exp_l});
            tick();
            m_req_ready = 1'b1;
            settle();
            check("tie_maddr", {m_req_valid, m_addr}, {1'b1, exp_l ? 32'h1000 + k : 32'h2000 + k});
            tick();
            m_req_ready = 1'b0; m_rsp_valid = 1'b1; m_rdata = 32'hC0DE_0000 + k;
            settle();
            check("tie_rsp", {lsu_rsp_valid, ifu_rsp_valid}, {exp_l, !exp_l});
            tick();
            m_rsp_valid = 1'b0;
        end
        clear_inputs();
        tick();

        // IFU-only fetch with an always-ready memory.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        settle();
        check("ifu_ready_n", {ifu_req_ready, m_req_valid}, 2'b10);
        tick();
        ifu_req_valid = 1'b0; ifu_addr = 32'h0; m_req_ready = 1'b1;
        settle();
        check("ifu_mreq_n1", {m_req_valid, m_wen, m_addr}, {1'b1, 1'b0, 32'h8000_0000});
        tick();
        m_req_ready = 1'b0; m_rsp_valid = 1'b1; m_rdata = 32'h0010_0093;
        settle();
        check("ifu_rsp_n2", {ifu_rsp_valid, lsu_rsp_valid, ifu_rdata}, {1'b1, 1'b0, 32'h0010_0093});
        tick();
        m_rsp_valid = 1'b0;
        settle();
        check("ifu_after", {ifu_rsp_valid, busy, ifu_req_ready}, 3'b000);

        // LSU store-byte with the memory stalling three cycles.
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0104;
        lsu_wdata = 32'h0000_00AB; lsu_wmask = 8'h01;
        settle();
        check("sb_ready", lsu_req_ready, 1'b1);
        tick();
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'hFFFF_FFFF;
        lsu_wdata = 32'h1234_5678; lsu_wmask = 8'hFF;
        for (int s = 0; s < 3; s++) begin
            settle();
            check("sb_stall", {m_req_valid, m_wen, m_addr, m_wdata, m_wmask},
                  {1'b1, 1'b1, 32'h8000_0104, 32'h0000_00AB, 8'h01});
            tick();
        end
        m_req_ready = 1'b1;
        settle();
        check("sb_accept", {m_req_valid, m_addr}, {1'b1, 32'h8000_0104});
        tick();
        m_req_ready = 1'b0;
        settle();
        check("sb_wait", {lsu_rsp_valid, busy, m_req_valid}, 3'b010);
        tick();
        m_rsp_valid = 1'b1; m_rdata = 32'hDEAD_BEEF;
        settle();
        check("sb_rsp", {lsu_rsp_valid, ifu_rsp_valid, lsu_rdata}, {1'b1, 1'b0, 32'h0});
        tick();
        m_rsp_valid = 1'b0;
        settle();
        check("sb_pulse", {lsu_rsp_valid, busy}, 2'b00);
        clear_inputs();

        // Stray responses in IDLE and in REQ are dropped.
        m_rsp_valid = 1'b1; m_rdata = 32'h5555_AAAA;
        settle();
        check("spur_idle", {lsu_rsp_valid, ifu_rsp_valid, busy}, 3'b000);
        tick();
        settle();
        check("spur_idle_st", busy, 1'b0);
        m_rsp_valid = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        tick();
        ifu_req_valid = 1'b0; m_rsp_valid = 1'b1;
        settle();
        check("spur_req", {lsu_rsp_valid, ifu_rsp_valid, m_req_valid}, 3'b001);
        tick();
        m_rsp_valid = 1'b0; m_req_ready = 1'b1;
        settle();
        check("spur_req_st", m_req_valid, 1'b1);
        tick();
        m_req_ready = 1'b0; m_rsp_valid = 1'b1; m_rdata = 32'h0BAD_F00D;
        settle();
        check("spur_real", {ifu_rsp_valid, ifu_rdata}, {1'b1, 32'h0BAD_F00D});
        tick();
        clear_inputs();

        // Reset while waiting for a load, then a late response.
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200;
        tick();
        lsu_req_valid = 1'b0; m_req_ready = 1'b1;
        tick();
        m_req_ready = 1'b0;
        settle();
        check("rstw_busy", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; m_rsp_valid = 1'b1; m_rdata = 32'h7777_7777;
        settle();
        check_reset_outputs("rstw");
        tick();
        clear_inputs();

        // Randomized traffic against a transaction-level model.
        l_hold = 0; i_hold = 0; busy_m = 0; mem_acc = 0; last_lsu = 0; cnt = 0;
        t_lsu = 0; t_wen = 0; t_addr = 0; t_wdata = 0; t_wmask = 0;
        l_wen = 0; l_addr = 0; l_wdata = 0; l_wmask = 0; i_addr = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!l_hold && $urandom_range(0, 9) < 4) begin
                l_hold = 1; l_wen = 1'($urandom_range(0, 1));
                l_addr = $urandom; l_wdata = $urandom;
                case ($urandom_range(0, 2))
                    0: l_wmask = 8'h01;
                    1: l_wmask = 8'h03;
                    default: l_wmask = 8'h0F;
                endcase
            end
            if (!i_hold && $urandom_range(0, 9) < 5) begin
                i_hold = 1; i_addr = $urandom;
            end
            lsu_req_valid = l_hold; lsu_wen = l_wen; lsu_addr = l_addr;
            lsu_wdata = l_wdata; lsu_wmask = l_wmask;
            ifu_req_valid = i_hold; ifu_addr = i_addr;
            m_req_ready = 1'($urandom_range(0, 1));
            rsp_now = busy_m && mem_acc && (cnt == 0);
            if (rsp_now) m_rsp_valid = 1'b1;
            else if (busy_m && mem_acc) m_rsp_valid = 1'b0;
            else m_rsp_valid = ($urandom_range(0, 7) == 0);
            m_rdata = $urandom;
            g_any = !busy_m && (l_hold || i_hold);
            if (l_hold && i_hold) g_lsu = RR ? !last_lsu : 1'b1;
            else g_lsu = l_hold;
            settle();
            check("rnd_ready", {lsu_req_ready, ifu_req_ready}, {g_any && g_lsu, g_any && !g_lsu});
            check("rnd_busy", busy, busy_m);
            check("rnd_mreq", m_req_valid, busy_m && !mem_acc);
            if (busy_m && !mem_acc)
                check("rnd_fields", {m_wen, m_addr, m_wdata, m_wmask}, {t_wen, t_addr, t_wdata, t_wmask});
            check("rnd_rsp", {lsu_rsp_valid, ifu_rsp_valid}, {rsp_now && t_lsu, rsp_now && !t_lsu});
            if (rsp_now)
                check("rnd_rdata", t_lsu ? lsu_rdata : ifu_rdata, (t_lsu && t_wen) ? 32'h0 : m_rdata);
            if (rsp_now) begin
                busy_m = 0;
            end else if (busy_m && mem_acc) begin
                cnt--;
            end else if (busy_m && m_req_ready) begin
                mem_acc = 1; cnt = $urandom_range(0, 3);
            end
            if (g_any) begin
                busy_m = 1; mem_acc = 0; t_lsu = g_lsu; last_lsu = g_lsu;
                if (g_lsu) begin
                    t_wen = l_wen; t_addr = l_addr; t_wdata = l_wdata; t_wmask = l_wmask; l_hold = 0;
                end else begin
                    t_wen = 0; t_addr = i_addr; t_wdata = 32'h0; t_wmask = 8'h00; i_hold = 0;
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
